mult_sequencer: RTL and testbench
=================================

Name: mult_sequencer

Overview:
Multi-cycle signed 32x32 -> 64 multiplier controller for the CPU MUL instruction. It retires one radix-4 Booth bit-pair digit per clock, replacing the single-cycle 16-partial-product adder tree. The control unit starts it and stalls on busy; on completion it pulses a write-enable for the HI/LO register pair.

Parameters:
WIDTH, 32, operand width; must be even and >= 4
ITER, WIDTH/2, number of Booth digits (localparam, not overridable)

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-high reset
start  in  1  request a multiply; sampled only in IDLE
m_in  in  WIDTH  multiplicand, signed two's complement
q_in  in  WIDTH  multiplier, signed two's complement
busy  out  1  high while digits are being processed (RUN)
done  out  1  one-cycle completion pulse (DONE)
hilo_we  out  1  HI/LO write enable; identical timing to done
hi_out  out  WIDTH  product bits [2*WIDTH-1:WIDTH]
lo_out  out  WIDTH  product bits [WIDTH-1:0]

Behaviour:
- Interface fixed: single clock clk; clr is asynchronous, active-high.
- clr asserted, at any time including mid-RUN: state=IDLE, digit counter=0, accumulator=0, busy=0, done=0, hilo_we=0, hi_out=0, lo_out=0. Takes effect immediately, not at the next edge.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on a rising edge with start=1. Latch m_in/q_in, clear the accumulator, set count=0.
  - RUN: on each edge, add the recoded digit of group {q[2c+1],q[2c],q[2c-1]} to the accumulator, where q[-1]=0 and c=count. The term is weighted by 4^c. Then count++.
  - RUN -> DONE on the edge that processes count=ITER-1.
  - DONE -> IDLE unconditionally after one cycle.
- Digit table: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
- Partial products are formed at WIDTH+2 bits, sign-extended to 2*WIDTH, then shifted. The accumulator is 2*WIDTH bits and wraps modulo 2^(2*WIDTH).
- Result: {hi_out,lo_out} equals signed(m)*signed(q) exactly. This includes M = -2^(WIDTH-1), where -2M needs the WIDTH+2 headroom.
- Timing: start captured at edge k; digits processed at edges k+1..k+ITER. done, hilo_we and the new hi_out/lo_out are valid from edge k+ITER until edge k+ITER+1. Latency is ITER+1 cycles; throughput is one op per ITER+2 cycles.
- hi_out/lo_out are registered and load only on entry to DONE. They hold their value otherwise.
- start during RUN or DONE is ignored; latched operands are unaffected. Operand inputs may change freely after capture.
- start held high continuously begins a new operation on the edge after DONE (the IDLE cycle).
- busy=1 exactly in RUN; done=hilo_we=1 exactly in DONE; never both.

Optional Feature:
MULT_EARLY_TERM_EN
- Defined: after processing digit c, if q[WIDTH-1:2c+1] are all 0 or all 1, every remaining digit is zero. The FSM then goes to DONE on that same edge.
- Minimum latency is 2 cycles; the result is identical.
- Not defined: always ITER digits; the termination logic is absent.

Decomposition:
- Shared package/include mult_pkg:
  - FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - Booth digit select codes (ZERO, POS1, POS2, NEG1, NEG2)
  - default WIDTH
- Sub-module booth_digit_recoder: combinational; maps 3-bit group + M to a WIDTH+2-bit signed partial product. Reused by the existing single-cycle multiplier.

Test Plan:
- clr pulse, then m=7, q=6, start 1 cycle -> busy for 16 cycles; done/hilo_we at edge k+16 for 1 cycle; hi=0x00000000, lo=0x0000002A.
- m=0x80000000, q=0x80000000 -> hi=0x40000000, lo=0x00000000. m=0x80000000, q=0x7FFFFFFF -> hi=0xC0000000, lo=0x80000000.
- m=0xFFFFFFFF (-1), q=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFFB.
- Back-to-back starts:
  - Start m=3, q=4, then assert start with m=9, q=9 at cycles k+5 and in DONE -> first result 12 only; second start ignored.
  - start held high continuously -> second op begins at the IDLE edge.
- clr asserted asynchronously at iteration 8 -> busy, done, hi and lo read 0 before the next edge; a following 7*6 still yields 42.
- With MULT_EARLY_TERM_EN:
  - q=3 -> done at edge k+2.
  - q=-1 -> done at edge k+1, product -m.
  - q=0x40000000 -> full 16 iterations.
- Without the macro: all three take 16 iterations; results identical.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the Booth multiplier datapath: FSM states, digit
// select codes, default operand width and the radix-4 group decoder.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SEL_ZERO,
    SEL_POS1,
    SEL_POS2,
    SEL_NEG1,
    SEL_NEG2
  } digit_sel_t;

  // Radix-4 Booth recoding of {q[2c+1], q[2c], q[2c-1]}
  function automatic digit_sel_t booth_select(input logic [2:0] grp);
    case (grp)
      3'b001, 3'b010: return SEL_POS1;
      3'b011:         return SEL_POS2;
      3'b100:         return SEL_NEG2;
      3'b101, 3'b110: return SEL_NEG1;
      default:        return SEL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_digit_recoder.sv
// Combinational radix-4 Booth digit: turns a 3-bit multiplier group and the
// multiplicand into a WIDTH+2-bit signed partial product (0, +-M, +-2M).
module booth_digit_recoder
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2:0]       group,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH+1:0] pp
);

  // Two guard bits so that -2M stays representable for M = -2^(WIDTH-1)
  logic [WIDTH+1:0] m_ext;
  assign m_ext = {{2{m[WIDTH-1]}}, m};

  always_comb begin
    pp = '0;
    case (booth_select(group))
      SEL_POS1: pp = m_ext;
      SEL_POS2: pp = m_ext << 1;
      SEL_NEG1: pp = -m_ext;
      SEL_NEG2: pp = -(m_ext << 1);
      default:  pp = '0;
    endcase
  end

endmodule

// File: rtl/mult_sequencer.sv
// Sequential signed WIDTHxWIDTH multiplier, one radix-4 Booth digit per clock.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining digits are zero.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] m_in,
  input  logic [WIDTH-1:0] q_in,
  output logic             busy,
  output logic             done,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int ITER = WIDTH / 2;
  localparam int CW   = $clog2(ITER) + 1;
  localparam int SW   = CW + 1;

  state_t             state_reg;
  logic [WIDTH-1:0]   m_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CW-1:0]      count_reg;

  logic [WIDTH:0]     q_ext;
  logic [SW-1:0]      shamt;
  logic [2:0]         group;
  logic [WIDTH+1:0]   pp;
  logic [2*WIDTH-1:0] pp_ext;
  logic [2*WIDTH-1:0] acc_next;
  logic               last_digit;

  // Appending a zero supplies the implicit q[-1] of the first group
  assign q_ext = {q_reg, 1'b0};
  assign shamt = {count_reg, 1'b0};
  assign group = q_ext[shamt +: 3];

  booth_digit_recoder #(.WIDTH(WIDTH)) u_recoder (
    .group (group),
    .m     (m_reg),
    .pp    (pp)
  );

  assign pp_ext   = {{(WIDTH-2){pp[WIDTH+1]}}, pp};
  assign acc_next = acc_reg + (pp_ext << shamt);

`ifdef MULT_EARLY_TERM_EN
  // Remaining digits are all zero once q[WIDTH-1:2c+1] is pure sign extension
  logic [WIDTH-1:0] q_rest;
  assign q_rest     = $signed(q_reg) >>> (shamt + SW'(1));
  assign last_digit = (count_reg == CW'(ITER - 1)) || (q_rest == '0) || (q_rest == '1);
`else
  assign last_digit = (count_reg == CW'(ITER - 1));
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= ST_IDLE;
      m_reg     <= '0;
      q_reg     <= '0;
      acc_reg   <= '0;
      count_reg <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hilo_we   <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            m_reg     <= m_in;
            q_reg     <= q_in;
            acc_reg   <= '0;
            count_reg <= '0;
            busy      <= 1'b1;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_reg   <= acc_next;
          count_reg <= count_reg + CW'(1);
          if (last_digit) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            hilo_we   <= 1'b1;
            hi_out    <= acc_next[2*WIDTH-1:WIDTH];
            lo_out    <= acc_next[WIDTH-1:0];
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          done      <= 1'b0;
          hilo_we   <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          hilo_we   <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: cycle-level reference model built on
// plain signed multiplication, directed corner cases and randomized traffic.
module tb_mult_sequencer;

  localparam int W = 32;

`ifdef MULT_EARLY_TERM_EN
  localparam int LAT_Q3  = 2;
  localparam int LAT_QM1 = 1;
`else
  localparam int LAT_Q3  = 16;
  localparam int LAT_QM1 = 16;
`endif
  localparam int LAT_Q40 = 16;

  logic          clk   = 1'b0;
  logic          clr   = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  m_in  = '0;
  logic [W-1:0]  q_in  = '0;
  logic          busy;
  logic          done;
  logic          hilo_we;
  logic [W-1:0]  hi_out;
  logic [W-1:0]  lo_out;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  mult_sequencer #(.WIDTH(W)) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .m_in    (m_in),
    .q_in    (q_in),
    .busy    (busy),
    .done    (done),
    .hilo_we (hilo_we),
    .hi_out  (hi_out),
    .lo_out  (lo_out)
  );

  always #5 clk = ~clk;

  // Number of digits the multiplier must spend on a given q
  function automatic int exp_digits(input logic [W-1:0] q);
`ifdef MULT_EARLY_TERM_EN
    logic signed [W-1:0] r;
    for (int c = 0; c < W / 2; c++) begin
      r = $signed(q) >>> (2 * c + 1);
      if (r == 0 || r == -1) return c + 1;
    end
    return W / 2;
`else
    return W / 2;
`endif
  endfunction

  // Reference model: product from plain arithmetic, timing from digit count
  bit          mdl_busy = 1'b0;
  bit          mdl_done = 1'b0;
  int          mdl_left = 0;
  logic [63:0] mdl_pend;
  logic [63:0] mdl_prod;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      mdl_busy <= 1'b0;
      mdl_done <= 1'b0;
      mdl_left <= 0;
      mdl_pend <= '0;
      mdl_prod <= '0;
    end else if (mdl_done) begin
      mdl_done <= 1'b0;
    end else if (mdl_busy) begin
      if (mdl_left == 1) begin
        mdl_busy <= 1'b0;
        mdl_done <= 1'b1;
        mdl_prod <= mdl_pend;
      end
      mdl_left <= mdl_left - 1;
    end else if (start) begin
      mdl_pend <= longint'($signed(m_in)) * longint'($signed(q_in));
      mdl_left <= exp_digits(q_in);
      mdl_busy <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("cycle busy/done/we", {61'b0, busy, done, hilo_we}, {61'b0, mdl_busy, mdl_done, mdl_done});
      chk("cycle hi:lo", {hi_out, lo_out}, mdl_prod);
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle wait", {63'b0, busy | done}, 64'd0);
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] m, input logic [W-1:0] q,
                        input logic [63:0] exp, input int lat);
    int n;
    wait_idle();
    m_in  = m;
    q_in  = q;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_in  = $urandom;
    q_in  = $urandom;
    wait_done(n);
    chk({name, " latency"}, 64'(n - 1), 64'(lat));
    chk({name, " product"}, {hi_out, lo_out}, exp);
    $display("op %s: m=0x%08h q=0x%08h -> 0x%016h after %0d edges", name, m, q, {hi_out, lo_out}, n - 1);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return {{28{r[3]}}, r[3:0]};
      5:       return 32'd1 << $urandom_range(0, 31);
      default: return r;
    endcase
  endfunction

  initial begin
    int n;
    #2 clr = 1'b1;
    #1;
    chk("reset flags", {61'b0, busy, done, hilo_we}, 64'd0);
    chk("reset hi:lo", {hi_out, lo_out}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    #2 clr = 1'b0;
    @(negedge clk);
    checking = 1'b1;

    run_op("7*6", 32'd7, 32'd6, 64'h0000_0000_0000_002A, exp_digits(32'd6));
    run_op("min*min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 16);
    run_op("min*max", 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 16);
    run_op("-1*5", 32'hFFFF_FFFF, 32'd5, 64'hFFFF_FFFF_FFFF_FFFB, exp_digits(32'd5));

    // Starts during RUN and DONE must not disturb the running op
    wait_idle();
    m_in = 32'd3; q_in = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    m_in = 32'd9; q_in = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("b2b first product", {hi_out, lo_out}, 64'd12);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // start held high: next op launches from the IDLE cycle after DONE
    wait_idle();
    m_in = 32'd7; q_in = 32'd6; start = 1'b1;
    @(negedge clk);
    m_in = 32'hFFFF_FFFD; q_in = 32'd5;
    wait_done(n);
    chk("held first product", {hi_out, lo_out}, 64'd42);
    @(negedge clk);
    chk("held idle gap busy", {63'b0, busy}, 64'd0);
    @(negedge clk);
    chk("held relaunch busy", {63'b0, busy}, 64'd1);
    start = 1'b0;
    wait_done(n);
    chk("held second product", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFF1);

    // Asynchronous clear in the middle of a run
    wait_idle();
    m_in = 32'h0001_2345; q_in = 32'h0765_4321; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    chk("async clr flags", {61'b0, busy, done, hilo_we}, 64'd0);
    chk("async clr hi:lo", {hi_out, lo_out}, 64'd0);
    #1 clr = 1'b0;
    @(negedge clk);
    run_op("7*6 after clr", 32'd7, 32'd6, 64'd42, exp_digits(32'd6));

    run_op("q=3", 32'd100, 32'd3, 64'd300, LAT_Q3);
    run_op("q=-1", 32'd100, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FF9C, LAT_QM1);
    run_op("q=2^30", 32'd3, 32'h4000_0000, 64'h0000_0000_C000_0000, LAT_Q40);

    // Random traffic with random start timing and occasional async clears
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      m_in  = pick();
      q_in  = pick();
      if ($urandom_range(0, 399) == 0) begin
        #2 clr = 1'b1;
        #1 clr = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
